// File: rtl/add_n_m_sched.sv
// Round-robin scheduler sharing one serial multi-operand adder between R requesters.
// A granted job's M operands are captured in one cycle, summed one per cycle,
// and the N-bit sum, sticky carry and requester id are offered on a valid/ready port.
module add_n_m_sched #(
    parameter int N = 32,
    parameter int M = 4,
    parameter int R = 4,
    localparam int IW = (R > 1) ? $clog2(R) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [R-1:0]         req_i,
    input  logic [N-1:0]         data_i [R][M],
    output logic [R-1:0]         gnt_o,
    output logic                 busy_o,
    output logic [N-1:0]         sum_o,
    output logic                 c_o,
    output logic [IW-1:0]        id_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LastId  = IW'(R - 1);
    localparam logic [CW-1:0] LastCnt = CW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    acc_q, acc_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   id_q, id_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    opBuf_q [M];
    logic [N-1:0]    opBuf_d [M];

    logic [IW:0]     scanIdx;
    logic [IW-1:0]   pickIdx;
    logic            pickValid;
    logic [N:0]      addSum;

    // Find the first requester at or after ptr, wrapping around the requester ring.
    always_comb begin
        scanIdx   = '0;
        pickIdx   = '0;
        pickValid = 1'b0;
        for (int i = 0; i < R; i++) begin
            scanIdx = {1'b0, ptr_q} + (IW + 1)'(i);
            if (scanIdx >= (IW + 1)'(R)) begin
                scanIdx = scanIdx - (IW + 1)'(R);
            end
            if (!pickValid && req_i[scanIdx[IW-1:0]]) begin
                pickValid = 1'b1;
                pickIdx   = scanIdx[IW-1:0];
            end
        end
    end

    // One N+1-bit add per ACC cycle; the top bit feeds the sticky carry.
    assign addSum = {1'b0, acc_q} + {1'b0, opBuf_q[cnt_q]};

    // Next-state logic for the grant/accumulate/deliver sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        id_d    = id_q;
        valid_d = valid_q;
        for (int k = 0; k < M; k++) begin
            opBuf_d[k] = opBuf_q[k];
        end

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    for (int k = 0; k < M; k++) begin
                        opBuf_d[k] = data_i[pickIdx][k];
                    end
                    id_d    = pickIdx;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d   = addSum[N-1:0];
                carry_d = carry_q | addSum[N];
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                    ptr_d   = (id_q == LastId) ? '0 : id_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset that drops any job in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < M; k++) begin
                opBuf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            for (int k = 0; k < M; k++) begin
                opBuf_q[k] <= opBuf_d[k];
            end
        end
    end

    assign gnt_o   = (state_q == IDLE && rst_i && pickValid) ? (R'(1) << pickIdx) : '0;
    assign busy_o  = (state_q == ACC) || (state_q == DONE);
    assign sum_o   = acc_q;
    assign c_o     = carry_q;
    assign id_o    = id_q;
    assign valid_o = valid_q;

endmodule
